// File: rtl/retire_merge.sv
// Merges six per-unit retire streams into one registered, backpressured stream.
// Each unit has its own FIFO; a round-robin arbiter feeds the output register.
module retire_merge #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        salu_retire_valid,
  input  logic [31:0] salu_retire_pc,
  input  logic [5:0]  salu_wfid,
  input  logic        simd1_retire_valid,
  input  logic [31:0] simd1_retire_pc,
  input  logic [5:0]  simd1_wfid,
  input  logic        simd2_retire_valid,
  input  logic [31:0] simd2_retire_pc,
  input  logic [5:0]  simd2_wfid,
  input  logic        simd3_retire_valid,
  input  logic [31:0] simd3_retire_pc,
  input  logic [5:0]  simd3_wfid,
  input  logic        simd4_retire_valid,
  input  logic [31:0] simd4_retire_pc,
  input  logic [5:0]  simd4_wfid,
  input  logic        lsu_retire_valid,
  input  logic [31:0] lsu_retire_pc,
  input  logic [5:0]  lsu_wfid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_wfid,
  output logic [2:0]  out_unit,
  output logic [5:0]  overflow,
  input  logic        clear_overflow,
  output logic [31:0] retire_count,
  output logic        all_empty
);
  localparam int unsigned NU = 6;

  logic [NU-1:0]    in_v;
  logic [37:0]      in_d    [NU];
  logic [37:0]      mem     [NU][DEPTH];
  logic [PTR_W-1:0] wr_ptr  [NU];
  logic [PTR_W-1:0] rd_ptr  [NU];
  logic [PTR_W:0]   occ     [NU];
  logic [2:0]       rr_ptr;
  logic [NU-1:0]    not_empty, full, pop, push_ok, drop;
  logic             load, found, grant;
  logic [2:0]       winner;
  logic [3:0]       idx;

  always_comb begin
    in_v = {lsu_retire_valid, simd4_retire_valid, simd3_retire_valid,
            simd2_retire_valid, simd1_retire_valid, salu_retire_valid};
    in_d[0] = {salu_retire_pc, salu_wfid};
    in_d[1] = {simd1_retire_pc, simd1_wfid};
    in_d[2] = {simd2_retire_pc, simd2_wfid};
    in_d[3] = {simd3_retire_pc, simd3_wfid};
    in_d[4] = {simd4_retire_pc, simd4_wfid};
    in_d[5] = {lsu_retire_pc, lsu_wfid};
  end

  // Arbitration looks at occupancy before this cycle's pushes; a full FIFO
  // that is popped this cycle still accepts its push.
  always_comb begin
    load   = !out_valid | out_ready;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned u = 0; u < NU; u++) begin
      not_empty[u] = occ[u] != '0;
      full[u]      = occ[u] == (PTR_W+1)'(DEPTH);
    end
    for (int unsigned i = 0; i < NU; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(NU)) idx = idx - 4'(NU);
      if (!found && not_empty[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
    grant   = load & found;
    pop     = grant ? (NU'(1) << winner) : '0;
    push_ok = in_v & (~full | pop);
    drop    = in_v & full & ~pop;
  end

  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < NU; u++)
      if (push_ok[u]) mem[u][wr_ptr[u]] <= in_d[u];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned u = 0; u < NU; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        occ[u]    <= '0;
      end
      rr_ptr       <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_wfid     <= '0;
      out_unit     <= '0;
      overflow     <= '0;
      retire_count <= '0;
    end else begin
      for (int unsigned u = 0; u < NU; u++) begin
        if (push_ok[u]) wr_ptr[u] <= wr_ptr[u] + 1'b1;
        if (pop[u])     rd_ptr[u] <= rd_ptr[u] + 1'b1;
        occ[u] <= occ[u] + (PTR_W+1)'(push_ok[u]) - (PTR_W+1)'(pop[u]);
      end
      if (load) begin
        if (grant) begin
          {out_pc, out_wfid} <= mem[winner][rd_ptr[winner]];
          out_unit           <= winner;
          out_valid          <= 1'b1;
          rr_ptr             <= (winner == 3'd5) ? 3'd0 : winner + 3'd1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      overflow     <= (clear_overflow ? '0 : overflow) | drop;
      retire_count <= retire_count + 32'(out_valid & out_ready);
    end
  end

  assign all_empty = !out_valid & ~|not_empty;

endmodule
